// File: rtl/negindex_pkg.sv
// Shared constants, types and expected-width arithmetic for the
// negative-index range width checker.
package negindex_pkg;

    localparam int GRID  = 4;
    localparam int NL    = GRID * GRID;
    localparam int LANEW = 8;
    localparam int BASE  = -2;
    localparam int AW    = $clog2(GRID);
    localparam int IW    = $clog2(NL);
    localparam int CW    = $clog2(NL + 1);

    localparam logic signed [7:0] BASE8 = 8'(BASE);

    typedef logic [LANEW-1:0] lane_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    // Width of [a+BASE : b+BASE]; BASE cancels, but the signed form mirrors the cosim source.
    function automatic lane_t expected_width(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic signed [7:0] msb;
        logic signed [7:0] lsb;
        logic signed [7:0] diff;
        msb  = $signed(8'(a)) + BASE8;
        lsb  = $signed(8'(b)) + BASE8;
        diff = msb - lsb;
        if (diff < 0) begin
            diff = -diff;
        end
        return lane_t'(diff + 8'sd1);
    endfunction

endpackage

// File: rtl/negindex_lane_sel.sv
// Combinational lane selector: picks the captured width for lane idx
// (lane 0 in the top byte) and the width that lane should carry.
module negindex_lane_sel
    import negindex_pkg::*;
(
    input  logic [NL*LANEW-1:0] cap,
    input  logic [IW-1:0]       idx,
    output logic [LANEW-1:0]    lane_width,
    output logic [LANEW-1:0]    lane_expected
);

    always_comb begin
        lane_width = '0;
        for (int k = 0; k < NL; k++) begin
            if (idx == IW'(k)) begin
                lane_width = cap[(NL-1-k)*LANEW +: LANEW];
            end
        end
    end

    assign lane_expected = expected_width(idx[IW-1:AW], idx[AW-1:0]);

endmodule

// File: rtl/negindex_width_checker.sv
// Captures the packed width vector on start, walks its lanes one per handshake
// and reports per-lane mismatch, a running error count and a final pass flag.
module negindex_width_checker
    import negindex_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NL*LANEW-1:0] widths_in,
    output logic                lane_valid,
    input  logic                lane_ready,
    output logic [IW-1:0]       lane_idx,
    output logic [LANEW-1:0]    lane_width,
    output logic [LANEW-1:0]    lane_expected,
    output logic                lane_mismatch,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [CW-1:0]       err_count
);

    state_t              state_q, state_d;
    logic [NL*LANEW-1:0] cap_q, cap_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [CW-1:0]       err_q, err_d;
    logic                pass_q, pass_d;
    logic                done_q, done_d;
    lane_t               sel_width;
    lane_t               sel_expected;
    logic                mismatch;

    negindex_lane_sel u_lane_sel (
        .cap           (cap_q),
        .idx           (idx_q),
        .lane_width    (sel_width),
        .lane_expected (sel_expected)
    );

    assign mismatch = (sel_width != sel_expected);

    // NOTE: blocking assignments here, so pass_d sees err_d including this lane's mismatch.
    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        idx_d   = idx_q;
        err_d   = err_q;
        pass_d  = pass_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SCAN;
                    cap_d   = widths_in;
                    idx_d   = '0;
                    err_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            SCAN: begin
                if (lane_ready) begin
                    if (mismatch && (err_q != CW'(NL))) begin
                        err_d = err_q + CW'(1);
                    end
                    if (idx_q == IW'(NL - 1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the capture register is reset too, so lane 0 reads width 0 straight out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cap_q   <= '0;
            idx_q   <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
        end
    end

    err_count_bound: assert property (@(posedge clk) disable iff (rst) err_q <= CW'(NL));

    assign lane_valid    = (state_q == SCAN);
    assign busy          = (state_q == SCAN);
    assign lane_idx      = idx_q;
    assign lane_width    = sel_width;
    assign lane_expected = sel_expected;
    assign lane_mismatch = mismatch;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_q;

endmodule
